// File: rtl/dcache_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dcache_pkg
// Purpose  : Shared FSM state encoding and address-field constants for the
//            direct-mapped data cache controller.
// Revision : 1.0 - initial release
// ============================================================================
package dcache_pkg;

    localparam int c_ADDR_W   = 32;
    localparam int c_DATA_W   = 32;
    localparam int c_OFFSET_W = 2;
    localparam int c_STAT_W   = 16;

    localparam logic [1:0] c_LSU_WAIT_MEM = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOOKUP  = 3'd1,
        ST_RD_REQ  = 3'd2,
        ST_RD_WAIT = 3'd3,
        ST_WR_REQ  = 3'd4,
        ST_RESP    = 3'd5
    } dc_state_e;

endpackage
`default_nettype wire

// File: rtl/dcache_array.sv
`default_nettype none
// ============================================================================
// Module   : dcache_array
// Purpose  : Tag/valid/data storage, one write port, combinational read.
// Revision : 1.0 - initial release
// ============================================================================
module dcache_array
    import dcache_pkg::*;
#(
    parameter int LINES = 16,
    parameter int TAG_W = c_ADDR_W - c_OFFSET_W - $clog2(LINES)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [$clog2(LINES)-1:0] i_rd_idx,
    output logic                     o_rd_valid,
    output logic [TAG_W-1:0]         o_rd_tag,
    output logic [c_DATA_W-1:0]      o_rd_data,
    input  logic                     i_we,
    input  logic [$clog2(LINES)-1:0] i_wr_idx,
    input  logic [TAG_W-1:0]         i_wr_tag,
    input  logic [c_DATA_W-1:0]      i_wr_data
);

    logic [LINES-1:0]    r_valid;
    logic [TAG_W-1:0]    r_tag  [LINES];
    logic [c_DATA_W-1:0] r_data [LINES];

    // Only valid bits need reset; tag/data are qualified by them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= '0;
        end else if (i_we) begin
            r_valid[i_wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_tag[i_wr_idx]  <= i_wr_tag;
            r_data[i_wr_idx] <= i_wr_data;
        end
    end

    assign o_rd_valid = r_valid[i_rd_idx];
    assign o_rd_tag   = r_tag[i_rd_idx];
    assign o_rd_data  = r_data[i_rd_idx];

endmodule
`default_nettype wire

// File: rtl/dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dcache_ctrl
// Purpose  : Direct-mapped, write-through, no-write-allocate data cache
//            controller. Define DCACHE_STATS_EN to build hit/miss counters.
// Revision : 1.0 - initial release
// ============================================================================
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int LINES = 16,
    parameter int TAG_W = c_ADDR_W - c_OFFSET_W - $clog2(LINES)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          lsu_state,
    input  logic                read_mem,
    input  logic                write_mem,
    input  logic [c_ADDR_W-1:0] addr,
    input  logic                addr_valid,
    input  logic [c_DATA_W-1:0] write_data,
    input  logic                write_data_valid,
    output logic                mem_done,
    output logic [c_DATA_W-1:0] DCache_data,
    output logic                mem_req,
    output logic                mem_we,
    output logic [c_ADDR_W-1:0] mem_addr,
    output logic [c_DATA_W-1:0] mem_wdata,
    input  logic                mem_ready,
    input  logic                mem_rvalid,
    input  logic [c_DATA_W-1:0] mem_rdata,
    output logic [c_STAT_W-1:0] hit_count,
    output logic [c_STAT_W-1:0] miss_count
);

    localparam int c_IDX_W  = $clog2(LINES);
    localparam int c_WORD_W = c_ADDR_W - c_OFFSET_W;

    dc_state_e           r_state;
    logic [c_WORD_W-1:0] r_word;
    logic [c_DATA_W-1:0] r_wdata;
    logic                r_is_read;

    logic                w_accept;
    logic [c_IDX_W-1:0]  w_idx;
    logic [TAG_W-1:0]    w_tag;
    logic                w_line_valid;
    logic [TAG_W-1:0]    w_line_tag;
    logic [c_DATA_W-1:0] w_line_data;
    logic                w_hit;
    logic                w_arr_we;
    logic [c_DATA_W-1:0] w_arr_data;
    logic                w_unused_addr_lsb;

    assign w_unused_addr_lsb = ^addr[c_OFFSET_W-1:0];

    assign w_accept = (r_state == ST_IDLE) && (lsu_state == c_LSU_WAIT_MEM) && addr_valid
                    && (read_mem || (write_mem && write_data_valid));

    assign w_idx = r_word[c_IDX_W-1:0];
    assign w_tag = r_word[c_WORD_W-1 -: TAG_W];
    assign w_hit = w_line_valid && (w_line_tag == w_tag);

    // Store hits refresh the line in LOOKUP; read misses fill it when data returns.
    assign w_arr_we   = ((r_state == ST_LOOKUP) && !r_is_read && w_hit)
                     || ((r_state == ST_RD_WAIT) && mem_rvalid);
    assign w_arr_data = (r_state == ST_RD_WAIT) ? mem_rdata : r_wdata;

    dcache_array #(
        .LINES (LINES),
        .TAG_W (TAG_W)
    ) u_array (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_rd_idx   (w_idx),
        .o_rd_valid (w_line_valid),
        .o_rd_tag   (w_line_tag),
        .o_rd_data  (w_line_data),
        .i_we       (w_arr_we),
        .i_wr_idx   (w_idx),
        .i_wr_tag   (w_tag),
        .i_wr_data  (w_arr_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_word      <= '0;
            r_wdata     <= '0;
            r_is_read   <= 1'b0;
            mem_done    <= 1'b0;
            DCache_data <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
        end else begin
            mem_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_word    <= addr[c_ADDR_W-1:c_OFFSET_W];
                        r_wdata   <= write_data;
                        r_is_read <= read_mem;
                        r_state   <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    mem_addr <= {r_word, {c_OFFSET_W{1'b0}}};
                    if (r_is_read && w_hit) begin
                        DCache_data <= w_line_data;
                        mem_done    <= 1'b1;
                        r_state     <= ST_RESP;
                    end else if (r_is_read) begin
                        mem_req <= 1'b1;
                        mem_we  <= 1'b0;
                        r_state <= ST_RD_REQ;
                    end else begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_wdata <= r_wdata;
                        r_state   <= ST_WR_REQ;
                    end
                end
                ST_RD_REQ: begin
                    // A same-cycle mem_rvalid is deliberately not looked at here.
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        r_state <= ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    if (mem_rvalid) begin
                        DCache_data <= mem_rdata;
                        mem_done    <= 1'b1;
                        r_state     <= ST_RESP;
                    end
                end
                ST_WR_REQ: begin
                    if (mem_ready) begin
                        mem_req  <= 1'b0;
                        mem_done <= 1'b1;
                        r_state  <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef DCACHE_STATS_EN
    logic [c_STAT_W-1:0] r_hit_count;
    logic [c_STAT_W-1:0] r_miss_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else if (r_state == ST_LOOKUP) begin
            if (w_hit) begin
                if (r_hit_count != '1) r_hit_count <= r_hit_count + 1'b1;
            end else begin
                if (r_miss_count != '1) r_miss_count <= r_miss_count + 1'b1;
            end
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcache_ctrl
// Purpose  : Randomised scoreboard bench for dcache_ctrl with a backing-memory
//            responder and a resident-line reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dcache_ctrl;

    localparam int LINES = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  lsu_state;
    logic        read_mem, write_mem, addr_valid, write_data_valid;
    logic [31:0] addr, write_data;
    logic        mem_done, mem_req, mem_we;
    logic [31:0] DCache_data, mem_addr, mem_wdata;
    logic        mem_ready, mem_rvalid;
    logic [31:0] mem_rdata;
    logic [15:0] hit_count, miss_count;

    always #5 clk = ~clk;

    dcache_ctrl #(.LINES(LINES)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .lsu_state        (lsu_state),
        .read_mem         (read_mem),
        .write_mem        (write_mem),
        .addr             (addr),
        .addr_valid       (addr_valid),
        .write_data       (write_data),
        .write_data_valid (write_data_valid),
        .mem_done         (mem_done),
        .DCache_data      (DCache_data),
        .mem_req          (mem_req),
        .mem_we           (mem_we),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_ready        (mem_ready),
        .mem_rvalid       (mem_rvalid),
        .mem_rdata        (mem_rdata),
        .hit_count        (hit_count),
        .miss_count       (miss_count)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h expected=%h", nm, act, exp);
        end
    endfunction

    function automatic logic [31:0] def_val(int w);
        return (w * 32'h9E37_79B9) ^ 32'h5A5A_1234;
    endfunction

    typedef struct {
        bit          is_read;
        bit          hit;
        logic [31:0] data;
        logic [31:0] maddr;
        logic [31:0] wdata;
        logic [31:0] held;
        int          c0;
        int          min_lat;
        logic [15:0] hc;
        logic [15:0] mc;
    } exp_t;

    exp_t sb[$];

    // Reference model: which tag is resident per line, and what memory holds.
    bit          m_valid [LINES];
    int          m_tag   [LINES];
    logic [31:0] ref_mem [int];
    int          m_hits, m_misses;
    logic [31:0] m_last_load;

    function automatic logic [31:0] ref_rd(int w);
        if (ref_mem.exists(w)) return ref_mem[w];
        return def_val(w);
    endfunction

    // Backing-memory responder
    logic [31:0] phys [int];
    int          n_rd, n_wr;
    logic [31:0] last_wr_addr, last_wr_data, last_rd_addr;
    int          rv_cnt = 0;
    logic [31:0] rv_data;
    bit          pend_acc = 0;
    bit          acc_we;
    logic [31:0] acc_addr, acc_wdata;
    int          hold_ready = 0;
    int          fixed_delay = 0;

    function automatic logic [31:0] phys_rd(int w);
        if (phys.exists(w)) return phys[w];
        return def_val(w);
    endfunction

    initial begin
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (pend_acc) begin
                if (acc_we) begin
                    n_wr++;
                    last_wr_addr = acc_addr;
                    last_wr_data = acc_wdata;
                    phys[int'(acc_addr[31:2])] = acc_wdata;
                end else begin
                    n_rd++;
                    last_rd_addr = acc_addr;
                    rv_data = phys_rd(int'(acc_addr[31:2]));
                    rv_cnt = (fixed_delay > 0) ? fixed_delay : $urandom_range(1, 3);
                end
                pend_acc = 0;
            end
            @(negedge clk);
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
            if (rv_cnt > 0) begin
                rv_cnt--;
                if (rv_cnt == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = rv_data;
                end
            end else if ($urandom_range(0, 7) == 0) begin
                mem_rvalid = 1'b1;
            end
            if (hold_ready > 0 && mem_req) begin
                mem_ready = 1'b0;
                hold_ready--;
            end else begin
                mem_ready = ($urandom_range(0, 3) != 0);
            end
            pend_acc  = mem_req && mem_ready;
            acc_we    = mem_we;
            acc_addr  = mem_addr;
            acc_wdata = mem_wdata;
        end
    end

    // Monitor: pops the scoreboard on every completion pulse.
    int done_cnt = 0;
    initial begin
        logic        prev_done;
        logic        prev_req;
        logic        pwe;
        logic [31:0] pa, pw;
        exp_t        e;
        int          lat;
        prev_done = 1'b0;
        prev_req  = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_done = 1'b0;
                prev_req  = 1'b0;
                continue;
            end
            if (mem_req && prev_req) begin
                chk("req_stable_addr", mem_addr, pa);
                chk("req_stable_we", {31'b0, mem_we}, {31'b0, pwe});
                chk("req_stable_wdata", mem_wdata, pw);
            end
            prev_req = mem_req;
            pa = mem_addr;
            pwe = mem_we;
            pw = mem_wdata;
            if (mem_done) begin
                done_cnt++;
                chk("done_one_cycle", {31'b0, prev_done}, 32'd0);
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: actual=pulse expected=none");
                end else begin
                    e = sb.pop_front();
                    lat = cyc - e.c0;
                    if (e.is_read) begin
                        chk("load_data", DCache_data, e.data);
                        chk("load_mem_reads", n_rd, e.hit ? 0 : 1);
                        chk("load_mem_writes", n_wr, 0);
                        if (!e.hit) chk("load_mem_addr", last_rd_addr, e.maddr);
                    end else begin
                        chk("store_mem_writes", n_wr, 1);
                        chk("store_mem_reads", n_rd, 0);
                        chk("store_addr", last_wr_addr, e.maddr);
                        chk("store_wdata", last_wr_data, e.wdata);
                        chk("store_held_data", DCache_data, e.held);
                    end
                    if (e.is_read && e.hit) chk("hit_latency", lat, 2);
                    else chk("min_latency_ok", {31'b0, lat >= e.min_lat}, 32'd1);
                    chk("hit_count", {16'b0, hit_count}, {16'b0, e.hc});
                    chk("miss_count", {16'b0, miss_count}, {16'b0, e.mc});
                end
            end
            prev_done = mem_done;
        end
    end

    task automatic issue(input bit rd, input bit wr, input logic [31:0] a,
                         input logic [31:0] wd, input int hold);
        exp_t e;
        int   w, idx, tag, start;
        @(negedge clk);
        n_rd = 0;
        n_wr = 0;
        hold_ready = hold;
        w   = int'(a[31:2]);
        idx = w % LINES;
        tag = w / LINES;
        e.hit = m_valid[idx] && (m_tag[idx] == tag);
        if (e.hit) m_hits++;
        else m_misses++;
        e.is_read = rd;
        e.maddr   = {a[31:2], 2'b00};
        e.wdata   = wd;
        e.c0      = cyc;
        e.min_lat = 3 + hold;
        if (rd) begin
            e.data = ref_rd(w);
            m_last_load = e.data;
            if (!e.hit) begin
                m_valid[idx] = 1'b1;
                m_tag[idx]   = tag;
            end
        end else begin
            e.data = '0;
            ref_mem[w] = wd;
        end
        e.held = m_last_load;
`ifdef DCACHE_STATS_EN
        e.hc = 16'(m_hits);
        e.mc = 16'(m_misses);
`else
        e.hc = 16'd0;
        e.mc = 16'd0;
`endif
        sb.push_back(e);
        lsu_state = 2'b10;
        read_mem = rd;
        write_mem = wr;
        addr = a;
        addr_valid = 1'b1;
        write_data = wd;
        write_data_valid = 1'b1;
        @(negedge clk);
        // Leave stale qualifiers up, as the LSU does in its idle state.
        lsu_state = ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b00;
        addr = $urandom;
        start = done_cnt;
        for (int k = 0; k < 200 && done_cnt == start; k++) @(negedge clk);
        if (done_cnt == start) begin
            total++;
            bad++;
            $display("FAIL done_timeout: actual=none expected=pulse addr=%h", a);
            sb.delete();
        end
    endtask

    task automatic noise();
        @(negedge clk);
        lsu_state = 2'b10; read_mem = 1'b0; write_mem = 1'b1;
        write_data_valid = 1'b0; addr_valid = 1'b1;
        @(negedge clk);
        read_mem = 1'b1; addr_valid = 1'b0; write_data_valid = 1'b1;
        @(negedge clk);
        lsu_state = 2'b11; addr_valid = 1'b1;
        @(negedge clk);
        lsu_state = 2'b01;
        repeat (3) @(negedge clk);
        chk("no_accept_req", {31'b0, mem_req}, 32'd0);
    endtask

    initial begin
        int          w, h;
        bit          rd, wr, got;
        logic [31:0] a;
        int          d0;
        rst_n = 1'b0;
        lsu_state = 2'b00; read_mem = 1'b0; write_mem = 1'b0; addr = '0;
        addr_valid = 1'b0; write_data = '0; write_data_valid = 1'b0;
        for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
        m_hits = 0; m_misses = 0; m_last_load = '0;
        phys[32'h40] = 32'hDEADBEEF;
        ref_mem[32'h40] = 32'hDEADBEEF;
        repeat (3) @(negedge clk);
        chk("rst_mem_done", {31'b0, mem_done}, 32'd0);
        chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_dcache_data", DCache_data, 32'd0);
        chk("rst_hit_count", {16'b0, hit_count}, 32'd0);
        chk("rst_miss_count", {16'b0, miss_count}, 32'd0);
        rst_n = 1'b1;

        fixed_delay = 3;
        issue(1, 0, 32'h100, 32'h0, 0);
        fixed_delay = 0;
        issue(1, 0, 32'h100, 32'h0, 0);
        issue(0, 1, 32'h100, 32'h12345678, 0);
        issue(1, 0, 32'h100, 32'h0, 0);
        issue(1, 0, 32'h140, 32'h0, 0);
        issue(1, 0, 32'h100, 32'h0, 0);
        issue(0, 1, 32'h144, 32'hCAFEF00D, 5);
        issue(1, 1, 32'h144, 32'h0BADF00D, 0);
        noise();

        // Reset while waiting for read data; the late response must be dropped.
        @(negedge clk);
        n_rd = 0;
        fixed_delay = 6;
        lsu_state = 2'b10; read_mem = 1'b1; write_mem = 1'b0;
        addr = 32'h3C0; addr_valid = 1'b1;
        @(negedge clk);
        lsu_state = 2'b00;
        got = 0;
        for (int k = 0; k < 50; k++) begin
            if (n_rd > 0) begin
                got = 1;
                break;
            end
            @(negedge clk);
        end
        chk("rdwait_reached", {31'b0, got}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        fixed_delay = 0;
        for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
        m_hits = 0; m_misses = 0; m_last_load = '0;
        chk("midrst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("midrst_mem_done", {31'b0, mem_done}, 32'd0);
        chk("midrst_dcache_data", DCache_data, 32'd0);
        d0 = done_cnt;
        repeat (10) @(negedge clk);
        chk("midrst_no_done", done_cnt, d0);
        issue(1, 0, 32'h100, 32'h0, 0);

        for (int i = 0; i < 150; i++) begin
            w  = $urandom_range(0, 63);
            a  = {w[29:0], 2'b00} | 32'($urandom_range(0, 3));
            rd = $urandom_range(0, 1) != 0;
            wr = rd ? ($urandom_range(0, 1) != 0) : 1'b1;
            h  = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 4) : 0;
            issue(rd, wr, a, $urandom, h);
            if ($urandom_range(0, 7) == 0) noise();
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
